// File: rtl/divmod_iter.sv
// divmod_iter: iterative restoring divider producing quotient and remainder, BITS_PER_CYCLE
// quotient bits per cycle, with zero-test early exit, divide-by-zero path and abort.
module divmod_iter #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   output logic             ready_i,
   input  logic             mode_i,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort_i,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             is_zero,
   output logic             div_by_zero,
   output logic             valid_o,
   input  logic             ready_o
);
   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   generate
      if (WIDTH < 2 || BITS_PER_CYCLE < 1 || WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_param
         $error("divmod_iter: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] quo;
   logic [WIDTH:0]   rem;
   logic             mode;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   r_nx;
   logic [WIDTH-1:0] d_nx;
   logic [WIDTH-1:0] q_nx;
   logic             last;

   // dvd shifts left as bits are consumed, so it is zero once no set dividend bits remain
   always_comb begin
      r_nx = rem;
      d_nx = dvd;
      q_nx = quo;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         r_nx = {r_nx[WIDTH-1:0], d_nx[WIDTH-1]};
         d_nx = d_nx << 1;
         q_nx = {q_nx[WIDTH-2:0], r_nx >= {1'b0, dvs}};
         r_nx = q_nx[0] ? r_nx - {1'b0, dvs} : r_nx;
      end
      last = cnt == CW'(1) || (mode && r_nx == '0 && d_nx == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         ready_i     <= 1'b1;
         valid_o     <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         is_zero     <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (valid_i && ready_i) begin
               ready_i <= 1'b0;
               if (b == '0) begin
                  state       <= DONE;
                  valid_o     <= 1'b1;
                  quotient    <= '1;
                  remainder   <= a;
                  is_zero     <= 1'b0;
                  div_by_zero <= 1'b1;
               end else begin
                  state <= RUN;
                  dvd   <= a;
                  dvs   <= b;
                  mode  <= mode_i;
                  rem   <= '0;
                  quo   <= '0;
                  cnt   <= CW'(N);
               end
            end
            RUN: if (abort_i) begin
               state   <= IDLE;
               ready_i <= 1'b1;
            end else begin
               rem <= r_nx;
               dvd <= d_nx;
               quo <= q_nx;
               cnt <= cnt - CW'(1);
               if (last) begin
                  state       <= DONE;
                  valid_o     <= 1'b1;
                  quotient    <= mode ? '0 : q_nx;
                  remainder   <= r_nx[WIDTH-1:0];
                  is_zero     <= r_nx[WIDTH-1:0] == '0;
                  div_by_zero <= 1'b0;
               end
            end
            DONE: if (ready_o) begin
               state   <= IDLE;
               valid_o <= 1'b0;
               ready_i <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_divmod_iter.sv
// tb_divmod_iter: directed vectors with hand-computed results for a 1-bit/cycle and a
// 4-bit/cycle divider sharing operand, abort and reset inputs.
module tb_divmod_iter;
   logic        clk = 1'b0;
   logic        rst_n, valid_i, valid4, mode_i, abort_i, ready_o;
   logic [31:0] a, b;
   logic        ready_i, is_zero, div_by_zero, valid_o;
   logic [31:0] quotient, remainder;
   logic        rdy4, iz4, dz4, v4;
   logic [31:0] q4, r4;
   int          checks = 0;
   int          errors = 0;
   int          lat;

   always #5 clk = ~clk;

   divmod_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_i(ready_i), .mode_i(mode_i),
      .a(a), .b(b), .abort_i(abort_i), .quotient(quotient), .remainder(remainder),
      .is_zero(is_zero), .div_by_zero(div_by_zero), .valid_o(valid_o), .ready_o(ready_o)
   );

   divmod_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .valid_i(valid4), .ready_i(rdy4), .mode_i(mode_i),
      .a(a), .b(b), .abort_i(abort_i), .quotient(q4), .remainder(r4),
      .is_zero(iz4), .div_by_zero(dz4), .valid_o(v4), .ready_o(ready_o)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] res();
      return {valid_o, ready_i, is_zero, div_by_zero, quotient, remainder};
   endfunction

   task automatic issue(input bit sel, input logic [31:0] av, input logic [31:0] bv, input logic m);
      a = av;
      b = bv;
      mode_i = m;
      if (sel) valid4 = 1'b1;
      else valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      valid4 = 1'b0;
   endtask

   task automatic wait_valid(input bit sel, output int n);
      n = 0;
      while (!(sel ? v4 : valid_o) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic release_out(input string tag);
      @(posedge clk);
      #1;
      check(tag, {valid_o, ready_i}, 2'b01);
   endtask

   initial begin
      rst_n = 1'b0; valid_i = 1'b0; valid4 = 1'b0; mode_i = 1'b0; abort_i = 1'b0;
      ready_o = 1'b1; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("reset", res(), {4'b0100, 64'd0});
      check("reset4", {v4, rdy4, iz4, dz4, q4, r4}, {4'b0100, 64'd0});

      issue(0, 100, 7, 0);
      wait_valid(0, lat);
      check("lat_100_7", lat, 32);
      check("res_100_7", res(), {4'b1000, 32'd14, 32'd2});
      release_out("hs_100_7");

      issue(0, 64, 8, 1);
      wait_valid(0, lat);
      check("lat_64_8_zt", lat, 29);
      check("res_64_8_zt", res(), {4'b1010, 32'd0, 32'd0});
      release_out("hs_64_8_zt");

      issue(0, 64, 8, 0);
      wait_valid(0, lat);
      check("lat_64_8", lat, 32);
      check("res_64_8", res(), {4'b1010, 32'd8, 32'd0});
      release_out("hs_64_8");

      issue(0, 100, 7, 1);
      wait_valid(0, lat);
      check("lat_100_7_zt", lat, 32);
      check("res_100_7_zt", res(), {4'b1000, 32'd0, 32'd2});
      release_out("hs_100_7_zt");

      issue(0, 5, 0, 0);
      wait_valid(0, lat);
      check("lat_dbz", lat, 0);
      check("res_dbz", res(), {4'b1001, 32'hFFFF_FFFF, 32'd5});
      release_out("hs_dbz");

      ready_o = 1'b0;
      issue(0, 1000, 33, 0);
      wait_valid(0, lat);
      check("lat_stall", lat, 32);
      for (int i = 0; i < 10; i++) begin
         check("stall", res(), {4'b1000, 32'd30, 32'd10});
         abort_i = (i >= 3 && i <= 5);
         @(posedge clk);
         #1;
      end
      abort_i = 1'b0;
      check("stall_end", res(), {4'b1000, 32'd30, 32'd10});
      ready_o = 1'b1;
      release_out("hs_stall");

      issue(0, 100, 7, 0);
      repeat (9) @(posedge clk);
      #1;
      abort_i = 1'b1;
      @(posedge clk);
      #1;
      abort_i = 1'b0;
      check("abort_idle", {valid_o, ready_i}, 2'b01);
      wait_valid(0, lat);
      check("abort_no_valid", lat, 100);

      issue(0, 100, 7, 0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("midrun_reset", res(), {4'b0100, 64'd0});
      wait_valid(0, lat);
      check("reset_no_valid", lat, 100);

      issue(0, 32'hFFFF_FFFF, 32'h1_0000, 0);
      wait_valid(0, lat);
      check("lat_big", lat, 32);
      check("res_big", res(), {4'b1000, 32'hFFFF, 32'hFFFF});
      release_out("hs_big");

      issue(1, 100, 7, 0);
      wait_valid(1, lat);
      check("lat4_100_7", lat, 8);
      check("res4_100_7", {v4, rdy4, iz4, dz4, q4, r4}, {4'b1000, 32'd14, 32'd2});
      @(posedge clk);
      #1;
      check("hs4", {v4, rdy4}, 2'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
